// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: FSM states, funct3 access sizes, fault codes.
package load_store_unit_pkg;
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam logic [1:0] S_DONE = 2'b11;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] FLT_NONE = 2'b00;
  localparam logic [1:0] FLT_MIS  = 2'b01;
  localparam logic [1:0] FLT_ILL  = 2'b10;
  localparam logic [1:0] FLT_TMO  = 2'b11;
endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables / lane replication, load lane select and extension,
// plus size legality and alignment checks.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  output logic [31:0] ext_rdata,
  output logic        legal,
  output logic        aligned
);
  logic [7:0]  rb;
  logic [15:0] rh;

  always_comb begin
    rb         = rdata_word[{off, 3'b000} +: 8];
    rh         = off[1] ? rdata_word[31:16] : rdata_word[15:0];
    be         = 4'b0000;
    lane_wdata = 32'h0;
    ext_rdata  = 32'h0;
    legal      = 1'b1;
    aligned    = 1'b1;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << off;
        lane_wdata = {4{wdata[7:0]}};
        ext_rdata  = {{24{rb[7] & ~funct3[2]}}, rb};
      end
      F3_H, F3_HU: begin
        be         = off[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata[15:0]}};
        ext_rdata  = {{16{rh[15] & ~funct3[2]}}, rh};
        aligned    = ~off[0];
      end
      F3_W: begin
        be         = 4'b1111;
        lane_wdata = wdata;
        ext_rdata  = rdata_word;
        aligned    = (off == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: converts datapath memory accesses into a req/gnt bus transaction,
// stalls the core while in flight, and reports misaligned/illegal/timed-out accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;
  logic        a_legal, a_aligned;
  logic        access, legal_acc, go, tmo_hit;

  // Lane logic sees live inputs while launching, and the latched access once in flight.
  assign a_f3  = (state == S_IDLE) ? funct3    : f3_q;
  assign a_off = (state == S_IDLE) ? addr[1:0] : off_q;

  lsu_align u_align (
    .funct3     (a_f3),
    .off        (a_off),
    .wdata      (wdata),
    .rdata_word (bus_rdata),
    .be         (a_be),
    .lane_wdata (a_wdata),
    .ext_rdata  (a_rdata),
    .legal      (a_legal),
    .aligned    (a_aligned)
  );

  assign access    = mem_read | mem_write;
  assign legal_acc = a_legal & ~(mem_write & funct3[2]);
  assign go        = access & legal_acc & a_aligned;
  assign tmo_hit   = (tmo_cnt == TMO_LAST);
  assign bus_req   = (state == S_REQ);
  assign stall     = reset & (((state == S_IDLE) & go) | (state == S_REQ) | (state == S_WAIT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      tmo_cnt    <= 8'd0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      rdata      <= 32'h0;
      fault      <= 1'b0;
      fault_code <= FLT_NONE;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_be     <= 4'b0000;
      bus_wdata  <= 32'h0;
    end else begin
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (!legal_acc) begin
              fault      <= 1'b1;
              fault_code <= FLT_ILL;
            end else if (!a_aligned) begin
              fault      <= 1'b1;
              fault_code <= FLT_MIS;
            end else begin
              bus_we    <= mem_write;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_be    <= a_be;
              bus_wdata <= a_wdata;
              f3_q      <= funct3;
              off_q     <= addr[1:0];
              tmo_cnt   <= 8'd0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            state   <= bus_we ? S_DONE : S_WAIT;
            tmo_cnt <= tmo_cnt + 8'd1;
          end else if (tmo_hit) begin
            state      <= S_DONE;
            fault      <= 1'b1;
            fault_code <= FLT_TMO;
            rdata      <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            rdata <= a_rdata;
            state <= S_DONE;
          end else if (tmo_hit) begin
            state      <= S_DONE;
            fault      <= 1'b1;
            fault_code <= FLT_TMO;
            rdata      <= 32'h0;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: one default instance, one with a short timeout.
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rst_t, mem_read, mem_write, bus_gnt, bus_rvalid;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;

  logic [31:0] rdata, bus_addr, bus_wdata, rdata_t, bus_addr_t, bus_wdata_t;
  logic        stall, fault, bus_req, bus_we, stall_t, fault_t, bus_req_t, bus_we_t;
  logic [1:0]  fault_code, fault_code_t;
  logic [3:0]  bus_be, bus_be_t;

  int checks = 0;
  int errors = 0;

  load_store_unit dut (
    .clk(clk), .reset(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
    .fault_code(fault_code), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  load_store_unit #(.TIMEOUT_CYC(4)) dut_t (
    .clk(clk), .reset(rst_t), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata_t), .stall(stall_t), .fault(fault_t),
    .fault_code(fault_code_t), .bus_req(bus_req_t), .bus_we(bus_we_t), .bus_addr(bus_addr_t),
    .bus_be(bus_be_t), .bus_wdata(bus_wdata_t), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Load with grant in the first REQ cycle and rvalid in the following cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input logic [3:0] be_exp, input logic [31:0] exp);
    mem_read = 1'b1; funct3 = f3; addr = a;
    mid(); chk({tag, "_stall_idle"}, 32'(stall), 32'd1);
    next();
    mem_read = 1'b0; bus_gnt = 1'b1;
    mid();
    chk({tag, "_req"}, 32'(bus_req), 32'd1);
    chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, "_be"}, 32'(bus_be), 32'(be_exp));
    chk({tag, "_we"}, 32'(bus_we), 32'd0);
    chk({tag, "_stall_req"}, 32'(stall), 32'd1);
    next();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = word;
    mid();
    chk({tag, "_stall_wait"}, 32'(stall), 32'd1);
    chk({tag, "_req_wait"}, 32'(bus_req), 32'd0);
    next();
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    mid();
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    chk({tag, "_rdata"}, rdata, exp);
    next();
  endtask

  task automatic do_fault(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [1:0] code);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    mid();
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_req0"}, 32'(bus_req), 32'd0);
    next();
    mem_read = 1'b0; mem_write = 1'b0;
    mid();
    chk({tag, "_fault"}, 32'(fault), 32'd1);
    chk({tag, "_code"}, 32'(fault_code), 32'(code));
    chk({tag, "_req1"}, 32'(bus_req), 32'd0);
    next();
    mid();
    chk({tag, "_pulse_end"}, 32'(fault), 32'd0);
    chk({tag, "_code_held"}, 32'(fault_code), 32'(code));
    next();
  endtask

  initial begin
    rst = 1'b0; rst_t = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    next(); next();
    mid();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_code", 32'(fault_code), 32'd0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_wdata", bus_wdata, 32'h0);
    next();
    rst = 1'b1;

    do_load("lw",  3'b010, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_load("lb3", 3'b000, 32'h103, 32'h80FFFF7F, 4'b1000, 32'hFFFFFF80);
    do_load("lbu3", 3'b100, 32'h103, 32'h80FFFF7F, 4'b1000, 32'h00000080);
    do_load("lb0", 3'b000, 32'h100, 32'h80FFFF7F, 4'b0001, 32'h0000007F);
    do_load("lh2", 3'b001, 32'h102, 32'h80FFFF7F, 4'b1100, 32'hFFFF80FF);
    do_load("lhu2", 3'b101, 32'h102, 32'h80FFFF7F, 4'b1100, 32'h000080FF);

    // sh with grant withheld for three REQ cycles; inputs change under it.
    mem_write = 1'b1; funct3 = 3'b001; addr = 32'h202; wdata = 32'h1234ABCD;
    mid(); chk("sh_stall_idle", 32'(stall), 32'd1);
    next();
    mem_write = 1'b0; addr = 32'hFFF; wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("sh_req", 32'(bus_req), 32'd1);
      chk("sh_addr", bus_addr, 32'h200);
      chk("sh_be", 32'(bus_be), 32'hC);
      chk("sh_wdata", bus_wdata, 32'hABCDABCD);
      chk("sh_we", 32'(bus_we), 32'd1);
      chk("sh_stall", 32'(stall), 32'd1);
      next();
    end
    bus_gnt = 1'b1;
    mid();
    chk("sh_req_gnt", 32'(bus_req), 32'd1);
    chk("sh_stall_gnt", 32'(stall), 32'd1);
    next();
    bus_gnt = 1'b0;
    mid();
    chk("sh_stall_done", 32'(stall), 32'd0);
    chk("sh_req_done", 32'(bus_req), 32'd0);
    next();

    // sw granted at once; mem_write kept high through DONE must not relaunch there.
    mem_write = 1'b1; funct3 = 3'b010; addr = 32'h40; wdata = 32'hCAFEF00D;
    next();
    bus_gnt = 1'b1;
    mid();
    chk("sw_be", 32'(bus_be), 32'hF);
    chk("sw_wdata", bus_wdata, 32'hCAFEF00D);
    next();
    bus_gnt = 1'b0;
    mid();
    chk("sw_stall_done", 32'(stall), 32'd0);
    chk("sw_req_done", 32'(bus_req), 32'd0);
    next();
    mid();
    chk("sw_idle_after_done", 32'(bus_req), 32'd0);
    mem_write = 1'b0;
    next();

    // sb to byte 1.
    mem_write = 1'b1; funct3 = 3'b000; addr = 32'h201; wdata = 32'h000000CD;
    next();
    mem_write = 1'b0; bus_gnt = 1'b1;
    mid();
    chk("sb_be", 32'(bus_be), 32'h2);
    chk("sb_wdata", bus_wdata, 32'hCDCDCDCD);
    chk("sb_addr", bus_addr, 32'h200);
    next();
    bus_gnt = 1'b0;
    next();

    do_fault("mis_lw", 1'b1, 1'b0, 3'b010, 32'h101, 2'b01);
    do_fault("mis_lh", 1'b1, 1'b0, 3'b001, 32'h103, 2'b01);
    do_fault("ill_011", 1'b1, 1'b0, 3'b011, 32'h100, 2'b10);
    do_fault("ill_110", 1'b1, 1'b0, 3'b110, 32'h100, 2'b10);
    do_fault("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h100, 2'b10);

    // Timeout instance: one good load, then an ungranted one.
    rst = 1'b0; rst_t = 1'b1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300;
    next();
    mem_read = 1'b0; bus_gnt = 1'b1;
    next();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h11223344;
    next();
    bus_rvalid = 1'b0;
    mid(); chk("t_lw_rdata", rdata_t, 32'h11223344);
    next();
    mem_read = 1'b1; addr = 32'h304;
    next();
    mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      chk("tmo_req", 32'(bus_req_t), 32'd1);
      chk("tmo_stall", 32'(stall_t), 32'd1);
      next();
    end
    mid();
    chk("tmo_req_low", 32'(bus_req_t), 32'd0);
    chk("tmo_fault", 32'(fault_t), 32'd1);
    chk("tmo_code", 32'(fault_code_t), 32'd3);
    chk("tmo_rdata", rdata_t, 32'h0);
    chk("tmo_stall_done", 32'(stall_t), 32'd0);
    next();
    bus_rvalid = 1'b1; bus_rdata = 32'h55555555;
    mid();
    chk("tmo_idle_fault", 32'(fault_t), 32'd0);
    chk("tmo_idle_req", 32'(bus_req_t), 32'd0);
    chk("tmo_idle_stall", 32'(stall_t), 32'd0);
    chk("tmo_code_held", 32'(fault_code_t), 32'd3);
    next();
    bus_rvalid = 1'b0;
    mid(); chk("tmo_late_rvalid", rdata_t, 32'h0);
    next();

    // Reset during WAIT on the default instance, then a stray rvalid.
    rst_t = 1'b0; rst = 1'b1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    next();
    mem_read = 1'b0; bus_gnt = 1'b1;
    next();
    bus_gnt = 1'b0; rst = 1'b0;
    next();
    rst = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'h99999999;
    mid();
    chk("rwait_stall", 32'(stall), 32'd0);
    chk("rwait_req", 32'(bus_req), 32'd0);
    chk("rwait_fault", 32'(fault), 32'd0);
    chk("rwait_rdata", rdata, 32'h0);
    next();
    bus_rvalid = 1'b0;
    mid();
    chk("rwait_rdata2", rdata, 32'h0);
    chk("rwait_fault2", 32'(fault), 32'd0);
    chk("rwait_stall2", 32'(stall), 32'd0);
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
